// File: rtl/pe_mac_cfg_if.sv
// Port bundle of one systolic processing element: west/north operands and
// partial sums in, registered east/south forwards, accumulator and drain chain out.
interface pe_mac_cfg_if #(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int ACC_W = 20
);
    logic                    mode;
    logic                    clr;
    logic signed [A_W-1:0]   a_in;
    logic                    a_vld_in;
    logic signed [B_W-1:0]   b_in;
    logic                    b_vld_in;
    logic                    w_load;
    logic signed [ACC_W-1:0] ps_in;
    logic                    drain;
    logic signed [ACC_W-1:0] drain_in;
    logic signed [A_W-1:0]   a_out;
    logic                    a_vld_out;
    logic signed [B_W-1:0]   b_out;
    logic                    b_vld_out;
    logic signed [ACC_W-1:0] ps_out;
    logic                    ps_vld_out;
    logic signed [ACC_W-1:0] acc_out;
    logic signed [ACC_W-1:0] drain_out;
    logic                    sat_flag;

    modport master (
        output mode, clr, a_in, a_vld_in, b_in, b_vld_in, w_load, ps_in, drain, drain_in,
        input  a_out, a_vld_out, b_out, b_vld_out, ps_out, ps_vld_out, acc_out, drain_out,
               sat_flag
    );

    modport slave (
        input  mode, clr, a_in, a_vld_in, b_in, b_vld_in, w_load, ps_in, drain, drain_in,
        output a_out, a_vld_out, b_out, b_vld_out, ps_out, ps_vld_out, acc_out, drain_out,
               sat_flag
    );
endinterface

// File: rtl/pe_mac_cfg.sv
// Systolic PE with runtime output-stationary / weight-stationary dataflow,
// optional saturation, sticky overflow flag and an accumulator drain chain.
module pe_mac_cfg #(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int ACC_W = 20,
    parameter bit SAT   = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    pe_mac_cfg_if.slave   bus
);
    localparam int PW = A_W + B_W;

    generate
        if (ACC_W < PW) begin : g_width_check
            $error("pe_mac_cfg: ACC_W must be at least A_W+B_W");
        end
    endgenerate

    logic signed [A_W-1:0]   a_reg;
    logic                    a_vld_reg;
    logic signed [B_W-1:0]   b_reg;
    logic                    b_vld_reg;
    logic signed [B_W-1:0]   w_reg, w_next;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic signed [ACC_W-1:0] ps_reg, ps_next;
    logic                    ps_vld_reg, ps_vld_next;
    logic                    sat_reg, sat_next;

    logic signed [B_W-1:0]   op_b;
    logic signed [PW-1:0]    prod_full;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] ws_addend;
    logic                    fire;
    logic [ACC_W:0]          os_res;
    logic [ACC_W:0]          ws_res;

    // Returns {overflow, result}; the add is done one bit wider so overflow
    // shows up as disagreement between the top two bits.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] x,
                                               input logic signed [ACC_W-1:0] y);
        logic signed [ACC_W:0] s;
        logic                  ovf;
        logic [ACC_W-1:0]      r;
        s   = {x[ACC_W-1], x} + {y[ACC_W-1], y};
        ovf = s[ACC_W] ^ s[ACC_W-1];
        if (SAT && ovf)
            r = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            r = s[ACC_W-1:0];
        return {ovf, r};
    endfunction

    // In WS mode the multiplier always sees the stored weight, so a same-cycle
    // w_load only affects the next product.
    assign op_b      = bus.mode ? w_reg : bus.b_in;
    assign prod_full = bus.a_in * op_b;
    assign prod      = ACC_W'(prod_full);
    assign fire      = bus.a_vld_in & bus.b_vld_in;
    assign ws_addend = bus.a_vld_in ? prod : '0;
    assign os_res    = sat_add(acc_reg, prod);
    assign ws_res    = sat_add(bus.ps_in, ws_addend);

    always_comb begin
        acc_next    = acc_reg;
        ps_next     = ps_reg;
        ps_vld_next = 1'b0;
        w_next      = w_reg;
        sat_next    = sat_reg;
        if (!bus.mode) begin
            if (bus.drain) begin
                acc_next = bus.drain_in;
            end else if (bus.clr) begin
                acc_next = fire ? prod : '0;
                sat_next = 1'b0;
            end else if (fire) begin
                acc_next = os_res[ACC_W-1:0];
                if (os_res[ACC_W])
                    sat_next = 1'b1;
            end
        end else begin
            if (bus.w_load)
                w_next = bus.b_in;
            ps_next     = ws_res[ACC_W-1:0];
            ps_vld_next = bus.a_vld_in;
            if (bus.drain)
                acc_next = bus.drain_in;
            if (bus.clr)
                sat_next = 1'b0;
            else if (ws_res[ACC_W])
                sat_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg      <= '0;
            a_vld_reg  <= 1'b0;
            b_reg      <= '0;
            b_vld_reg  <= 1'b0;
            w_reg      <= '0;
            acc_reg    <= '0;
            ps_reg     <= '0;
            ps_vld_reg <= 1'b0;
            sat_reg    <= 1'b0;
        end else begin
            a_reg      <= bus.a_in;
            a_vld_reg  <= bus.a_vld_in;
            b_reg      <= bus.b_in;
            b_vld_reg  <= bus.b_vld_in;
            w_reg      <= w_next;
            acc_reg    <= acc_next;
            ps_reg     <= ps_next;
            ps_vld_reg <= ps_vld_next;
            sat_reg    <= sat_next;
        end
    end

    assign bus.a_out      = a_reg;
    assign bus.a_vld_out  = a_vld_reg;
    assign bus.b_out      = b_reg;
    assign bus.b_vld_out  = b_vld_reg;
    assign bus.ps_out     = ps_reg;
    assign bus.ps_vld_out = ps_vld_reg;
    assign bus.acc_out    = acc_reg;
    assign bus.drain_out  = acc_reg;
    assign bus.sat_flag   = sat_reg;
endmodule
